// File: rtl/cpu_pkg.sv
// cpu_pkg: types, field positions and opcode constants shared by the CPU front end
// and the microcode control unit.
package cpu_pkg;

  // Fetch sequencer states; encoding is visible to debug tooling, so keep it fixed.
  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_LATCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_FAULT = 2'd3
  } fetch_state_e;

  // Instruction field widths: opcode sits in the top bits, flag-select just below it.
  localparam int OPC_W  = 5;
  localparam int FSEL_W = 2;

  // Opcodes the control unit decodes into stack operations.
  localparam logic [OPC_W-1:0] OPC_NOP  = 5'b00000;
  localparam logic [OPC_W-1:0] OPC_CALL = 5'b10110;
  localparam logic [OPC_W-1:0] OPC_RET  = 5'b10111;  // unconditional return
  localparam logic [OPC_W-1:0] OPC_RETC = 5'b11000;  // flag-conditional return

  // MSB of the opcode field for a given instruction width.
  function automatic int opc_msb(input int instr_w);
    return instr_w - 1;
  endfunction

  // MSB of the flag-select field for a given instruction width.
  function automatic int fsel_msb(input int instr_w);
    return instr_w - 1 - OPC_W;
  endfunction

endpackage

// File: rtl/ret_stack.sv
// ret_stack: small LIFO of return addresses. Reports an error when asked to push
// while full or pop while empty; the offending operation has no effect.
module ret_stack
  import cpu_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] push_data,
  output logic [DATA_W-1:0] top_data,
  output logic              full,
  output logic              empty,
  output logic              err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int SP_W  = IDX_W + 1;

  // sp counts valid entries, so it needs one bit more than the index to reach DEPTH.
  logic [SP_W-1:0]   sp_q, sp_d;
  logic [DATA_W-1:0] stack_mem [DEPTH];
  logic [IDX_W-1:0]  wr_idx, rd_idx;
  logic              push_ok, pop_ok;

  assign full    = (sp_q == SP_W'(DEPTH));
  assign empty   = (sp_q == '0);
  // Pop takes precedence if both are requested; the parent never does that.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && !pop && !full;
  assign err     = (pop && empty) || (push && !pop && full);

  // Low bits of sp address the next free slot; wrap at DEPTH is harmless when full.
  assign wr_idx   = sp_q[IDX_W-1:0];
  assign rd_idx   = wr_idx - IDX_W'(1);
  assign top_data = stack_mem[rd_idx];

  // Stack-pointer update for a successful push or pop.
  always_comb begin
    sp_d = sp_q;
    if (pop_ok) begin
      sp_d = sp_q - SP_W'(1);
    end else if (push_ok) begin
      sp_d = sp_q + SP_W'(1);
    end
  end

  // Stack pointer register; only sp needs a reset, entries are don't-care when empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q <= '0;
    end else begin
      sp_q <= sp_d;
    end
  end

  // Entry storage written on a successful push.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      stack_mem[wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: CPU front end. Owns the PC, sequences the synchronous program ROM
// through FETCH/LATCH/EXEC, and applies the control unit's next-PC request in EXEC.
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int                ADDR_W      = 16,
  parameter int                INSTR_W     = 32,
  parameter int                STACK_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_VEC   = '0
) (
  input  logic               CLK,
  input  logic               RSTn,
  input  logic               PCpp,
  input  logic               JMP,
  input  logic               ret,
  input  logic               Call,
  input  logic               Stall,
  input  logic [INSTR_W-1:0] ROMdata,
  output logic [ADDR_W-1:0]  ROMaddr,
  output logic [OPC_W-1:0]   OPCode,
  output logic [FSEL_W-1:0]  A,
  output logic [INSTR_W-1:0] IR,
  output logic               IRvalid,
  output logic               Fault
);

  localparam int OPC_MSB  = opc_msb(INSTR_W);
  localparam int FSEL_MSB = fsel_msb(INSTR_W);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [ADDR_W-1:0]  pc_inc, target, stack_top;
  logic               exec_go, stack_push, stack_pop;
  logic               stack_full, stack_empty, stack_err;

  // PC+1 wraps naturally at the address width; the same value is pushed by Call.
  assign pc_inc = pc_q + ADDR_W'(1);
  assign target = ir_q[ADDR_W-1:0];

  // Stack operations only fire on the EXEC cycle that actually retires.
  // ret outranks Call, and ret always comes with JMP, so JMP is not consulted here.
  assign exec_go    = (state_q == ST_EXEC) && !Stall;
  assign stack_pop  = exec_go && ret;
  assign stack_push = exec_go && !ret && Call;

  ret_stack #(
    .DEPTH  (STACK_DEPTH),
    .DATA_W (ADDR_W)
  ) u_ret_stack (
    .clk       (CLK),
    .rst_n     (RSTn),
    .push      (stack_push),
    .pop       (stack_pop),
    .push_data (pc_inc),
    .top_data  (stack_top),
    .full      (stack_full),
    .empty     (stack_empty),
    .err       (stack_err)
  );

  // Next state, IR load in LATCH and next-PC selection in EXEC (ret > Call > JMP > PCpp).
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      ST_FETCH: begin
        state_d = ST_LATCH;
      end
      ST_LATCH: begin
        ir_d    = ROMdata;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (!Stall) begin
          state_d = ST_FETCH;
          if (ret) begin
            if (!stack_empty) pc_d = stack_top;
          end else if (Call) begin
            if (!stack_full) pc_d = target;
          end else if (JMP) begin
            pc_d = target;
          end else if (PCpp) begin
            pc_d = pc_inc;
          end
          // A rejected push/pop leaves the PC on the faulting instruction.
          if (stack_err) state_d = ST_FAULT;
        end
      end
      default: begin
        // ST_FAULT: everything frozen until reset
      end
    endcase
  end

  // State, PC and IR registers.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_VEC;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  assign ROMaddr = pc_q;
  assign IR      = ir_q;
  assign OPCode  = ir_q[OPC_MSB -: OPC_W];
  assign A       = ir_q[FSEL_MSB -: FSEL_W];
  assign IRvalid = (state_q == ST_EXEC);
  assign Fault   = (state_q == ST_FAULT);

endmodule
